// File: rtl/tt_um_pwm_generator_verilog_if.sv
// tt_um_pwm_generator_verilog_if: button inputs and PWM output of the PWM tile
interface tt_um_pwm_generator_verilog_if;
  logic ui_increase_duty;
  logic ui_decrease_duty;
  logic uo_PWM_OUT;
  modport master(output ui_increase_duty, ui_decrease_duty, input uo_PWM_OUT);
  modport slave(input ui_increase_duty, ui_decrease_duty, output uo_PWM_OUT);
endinterface

// File: rtl/tt_um_pwm_generator_verilog.sv
// tt_um_pwm_generator_verilog: fixed-period PWM with debounced duty up/down buttons; define PWM_OUT_REG_EN to register the output
module tt_um_pwm_generator_verilog #(
  parameter int PERIOD       = 10,
  parameter int DUTY_INIT    = 5,
  parameter int DUTY_STEP    = 1,
  parameter int DEBOUNCE_DIV = 4
) (
  input logic clk,
  input logic rst,
  tt_um_pwm_generator_verilog_if.slave bus
);
  localparam int DW = $clog2(PERIOD + 1);
  localparam int VW = $clog2(DEBOUNCE_DIV);
  localparam logic [DW-1:0] P    = DW'(PERIOD);
  localparam logic [DW-1:0] S    = DW'(DUTY_STEP);
  localparam logic [DW-1:0] LAST = DW'(PERIOD - 1);
  logic [DW-1:0] cnt, duty, duty_nxt;
  logic [VW-1:0] div;
  logic [1:0] sync0, sync1, q1, q2, strobe;
  logic tick, pwm;
  assign tick   = div == VW'(DEBOUNCE_DIV - 1);
  // bit 0 is increase, bit 1 is decrease; simultaneous strobes cancel
  assign strobe = {2{tick}} & q1 & ~q2;
  assign pwm    = cnt < duty;
  always_comb
    duty_nxt = strobe == 2'b01 ? (duty > P - S ? P : duty + S) :
               strobe == 2'b10 ? (duty < S ? '0 : duty - S) : duty;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync0 <= '0;
      sync1 <= '0;
      q1    <= '0;
      q2    <= '0;
      div   <= '0;
      cnt   <= '0;
      duty  <= DW'(DUTY_INIT);
    end else begin
      sync0 <= {bus.ui_decrease_duty, bus.ui_increase_duty};
      sync1 <= sync0;
      div   <= tick ? '0 : div + VW'(1);
      if (tick) begin
        q1 <= sync1;
        q2 <= q1;
      end
      cnt   <= cnt == LAST ? '0 : cnt + DW'(1);
      duty  <= duty_nxt;
    end
`ifdef PWM_OUT_REG_EN
  logic pwm_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) pwm_q <= 1'b0;
    else     pwm_q <= pwm;
  assign bus.uo_PWM_OUT = pwm_q;
`else
  assign bus.uo_PWM_OUT = pwm;
`endif
endmodule

// File: tb/tb_tt_um_pwm_generator_verilog.sv
// tb_tt_um_pwm_generator_verilog: random button presses against an arithmetic duty/period model
module tb_tt_um_pwm_generator_verilog;
  localparam int PERIOD = 10, DUTY_INIT = 5, DUTY_STEP = 1, DIV = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int duty_m = DUTY_INIT;
  int n_vec = 0;
  int n_err = 0;
  tt_um_pwm_generator_verilog_if bus();
  tt_um_pwm_generator_verilog #(
    .PERIOD(PERIOD), .DUTY_INIT(DUTY_INIT), .DUTY_STEP(DUTY_STEP), .DEBOUNCE_DIV(DIV)
  ) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
  task automatic check(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %b expected %b (model duty %0d)", tag, cyc, got, exp, duty_m);
    end
  endtask
  function automatic logic exp_pwm();
`ifdef PWM_OUT_REG_EN
    return rst ? 1'b0 : ((cyc - 1) % PERIOD) < duty_m;
`else
    return rst ? (0 < duty_m) : (cyc % PERIOD) < duty_m;
`endif
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_period(input string tag);
    repeat (PERIOD) begin
      step();
      check(tag, bus.uo_PWM_OUT, exp_pwm());
    end
  endtask
  task automatic press(input bit i, input bit d, input int hold, input int gap);
    bus.ui_increase_duty = i;
    bus.ui_decrease_duty = d;
    repeat (hold) step();
    bus.ui_increase_duty = 1'b0;
    bus.ui_decrease_duty = 1'b0;
    if (i && !d) duty_m = (duty_m + DUTY_STEP > PERIOD) ? PERIOD : duty_m + DUTY_STEP;
    if (d && !i) duty_m = (duty_m < DUTY_STEP) ? 0 : duty_m - DUTY_STEP;
    repeat (gap) step();
  endtask
  task automatic do_reset(input int len);
    #($urandom_range(1, 8));
    rst = 1'b1;
    duty_m = DUTY_INIT;
    #1;
    check("reset_out", bus.uo_PWM_OUT, exp_pwm());
    repeat (len) step();
    rst = 1'b0;
  endtask
  initial begin
    bus.ui_increase_duty = 1'b0;
    bus.ui_decrease_duty = 1'b0;
    repeat (3) step();
    check("reset_out", bus.uo_PWM_OUT, exp_pwm());
    rst = 1'b0;
    repeat (3) check_period("idle_5_5");
    repeat (3) begin
      press(1, 0, 10, 10);
      check_period("inc_step");
    end
    repeat (3) begin
      press(0, 1, 10, 10);
      check_period("dec_step");
    end
    repeat (7) press(1, 0, 10, 10);
    check_period("sat_high");
    repeat (12) press(0, 1, 10, 10);
    check_period("sat_low");
    repeat (8) press(1, 0, 10, 10);
    check_period("duty_8");
    press(1, 0, 200, 10);
    check_period("hold_once");
    press(1, 1, 10, 10);
    check_period("both_cancel");
    while (cyc % DIV != 2) step();
    bus.ui_increase_duty = 1'b1;
    repeat (2) step();
    bus.ui_increase_duty = 1'b0;
    repeat (12) step();
    check_period("glitch");
    press(0, 1, 10, 10);
    check_period("duty_8_again");
    repeat (3) step();
    do_reset(3);
    check_period("after_reset");
    repeat (40) begin
      case ($urandom_range(0, 9))
        0:       press(1, 1, $urandom_range(10, 30), $urandom_range(10, 20));
        1, 2, 3: press(0, 1, $urandom_range(10, 40), $urandom_range(10, 20));
        9:       do_reset($urandom_range(1, 5));
        default: press(1, 0, $urandom_range(10, 40), $urandom_range(10, 20));
      endcase
      check_period("random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
